// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DIGIT_W     = 4;
   localparam int NDIGITS_DEF = 8;
   localparam int BIN_W_DEF   = 27;
endpackage

// File: rtl/bcd_conv_sched_if.sv
// rtl/bcd_conv_sched_if.sv - request/result handshake bundle for bcd_conv_sched
interface bcd_conv_sched_if #(
   parameter int NDIGITS = 8,
   parameter int BIN_W   = 27
);
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [4*NDIGITS-1:0] req_bcd0;
   logic [4*NDIGITS-1:0] req_bcd1;
   logic                 out_valid;
   logic                 out_ready;
   logic [BIN_W-1:0]     out_data;
   logic                 out_id;
   logic                 out_err;
   logic                 busy;

   modport master (
      output req_valid, req_bcd0, req_bcd1, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_err, busy
   );

   modport slave (
      input  req_valid, req_bcd0, req_bcd1, out_ready,
      output req_ready, out_valid, out_data, out_id, out_err, busy
   );
endinterface

// File: rtl/bcd_rr_arb2.sv
// rtl/bcd_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module bcd_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       done,
   output logic [1:0] grant
);
   logic last_q;

   // Contention goes to whoever was not served last; a lone request always wins.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11)
         grant = last_q ? 2'b01 : 2'b10;
      else
         grant = req;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_q <= 1'b1;
      else if (done)
         last_q <= grant[1];
   end
endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - arbitrated serial BCD-to-binary converter, one digit per cycle
// Optional nibble range check: BCD_CONV_SCHED_DIGIT_CHECK_EN
module bcd_conv_sched
   import bcd_pkg::*;
#(
   parameter int NDIGITS = NDIGITS_DEF,
   parameter int BIN_W   = BIN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   bcd_conv_sched_if.slave  bus
);
   localparam int WORD_W = DIGIT_W * NDIGITS;
   localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   state_t              state_q, state_d;
   logic [1:0]          grant;
   logic                hs;
   logic                last_digit;
   logic [WORD_W-1:0]   word_q;
   logic [DIGIT_W-1:0]  nib;
   logic [BIN_W-1:0]    acc_q, acc_next;
   logic [IDX_W-1:0]    idx_q;
   logic [BIN_W-1:0]    out_data_q;
   logic                out_id_q;

   bcd_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (bus.req_valid),
      .done  (hs),
      .grant (grant)
   );

   assign bus.req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
   assign hs            = |bus.req_ready;

   // The word is shifted left each RUN cycle so the current digit is always the top nibble.
   assign nib        = word_q[WORD_W-1 -: DIGIT_W];
   assign acc_next   = (acc_q << 3) + (acc_q << 1) + {{(BIN_W-DIGIT_W){1'b0}}, nib};
   assign last_digit = (idx_q == IDX_W'(NDIGITS - 1));

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs) state_d = RUN;
         RUN:     if (last_digit) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q     <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         out_id_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  word_q   <= grant[1] ? bus.req_bcd1 : bus.req_bcd0;
                  acc_q    <= '0;
                  idx_q    <= '0;
                  out_id_q <= grant[1];
               end
            end
            RUN: begin
               acc_q  <= acc_next;
               word_q <= word_q << DIGIT_W;
               idx_q  <= idx_q + 1'b1;
               if (last_digit)
                  out_data_q <= acc_next;
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_CONV_SCHED_DIGIT_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (state_q == IDLE && hs)
         err_q <= 1'b0;
      else if (state_q == RUN && nib > 4'd9)
         err_q <= 1'b1;
   end

   assign bus.out_err = (state_q == DONE) && err_q;
`else
   assign bus.out_err = 1'b0;
`endif

   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - randomized self-checking bench for bcd_conv_sched
// Expected out_err follows BCD_CONV_SCHED_DIGIT_CHECK_EN when defined.
module tb_bcd_conv_sched;
   localparam int NDIGITS = 8;
   localparam int BIN_W   = 27;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   last_served = 1;

   bcd_conv_sched_if #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) bus ();

   bcd_conv_sched #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Decimal value as a weighted sum of digits, reduced to BIN_W bits.
   function automatic longint ref_value(input logic [31:0] w);
      longint v = 0;
      longint p = 1;
      for (int k = 0; k < NDIGITS; k++) begin
         v += longint'(w[4*k +: 4]) * p;
         p *= 10;
      end
      return v & ((longint'(1) << BIN_W) - 1);
   endfunction

   function automatic logic ref_err(input logic [31:0] w);
      logic e = 1'b0;
`ifdef BCD_CONV_SCHED_DIGIT_CHECK_EN
      for (int k = 0; k < NDIGITS; k++)
         if (w[4*k +: 4] > 4'd9) e = 1'b1;
`else
      e = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      if ($urandom_range(0, 3) == 0)
         w = $urandom;
      else
         for (int k = 0; k < NDIGITS; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
      return w;
   endfunction

   // Called at a negedge with the FSM idle and request inputs already driven.
   task automatic serve(input int hold, input bit drop);
      int          id;
      int          lat;
      logic [1:0]  pend;
      logic [31:0] w;
      longint      expv;
      logic        experr;
      pend = bus.req_valid;
      if (pend == 2'b11) id = (last_served == 1) ? 0 : 1;
      else id = pend[1] ? 1 : 0;
      w      = id ? bus.req_bcd1 : bus.req_bcd0;
      expv   = ref_value(w);
      experr = ref_err(w);
      #1;
      check("req_ready_grant", bus.req_ready, (id == 1) ? 2'b10 : 2'b01);
      @(posedge clk);
      last_served = id;
      @(negedge clk);
      if (drop) bus.req_valid[id] = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 60) begin
         check("req_ready_run", bus.req_ready, 2'b00);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, NDIGITS);
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", bus.out_valid, 1'b1);
         check("hold_data", bus.out_data, expv);
         check("hold_ready", bus.req_ready, 2'b00);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      check("out_valid", bus.out_valid, 1'b1);
      check("out_data", bus.out_data, expv);
      check("out_id", bus.out_id, id);
      check("out_err", bus.out_err, experr);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("idle_busy", bus.busy, 1'b0);
      check("idle_valid", bus.out_valid, 1'b0);
   endtask

   task automatic single(input int who, input logic [31:0] w, input int hold);
      if (who == 1) bus.req_bcd1 = w;
      else bus.req_bcd0 = w;
      bus.req_valid = (who == 1) ? 2'b10 : 2'b01;
      serve(hold, 1'b1);
   endtask

   initial begin
      logic seen;
      reset         = 1'b1;
      bus.req_valid = 2'b11;
      bus.req_bcd0  = 32'h0000_0001;
      bus.req_bcd1  = 32'h9999_9999;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_ready", bus.req_ready, 2'b00);
      check("rst_data", bus.out_data, 0);
      check("rst_id", bus.out_id, 0);
      check("rst_err", bus.out_err, 0);
      reset = 1'b0;
      last_served = 1;

      // Both requesters pending continuously: service must alternate.
      for (int r = 0; r < 4; r++) serve(r, 1'b0);
      bus.req_valid = 2'b00;

      single(0, 32'h1234_5678, 0);
      single(1, 32'h0000_0000, 5);
      single(0, 32'h9999_9999, 1);
      single(1, 32'h0000_000A, 2);

      for (int it = 0; it < 25; it++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         bus.req_bcd0  = rand_word();
         bus.req_bcd1  = rand_word();
         bus.req_valid = m;
         serve($urandom_range(0, 3), 1'b1);
         if (bus.req_valid != 2'b00) serve($urandom_range(0, 2), 1'b1);
      end

      // Abort mid-RUN from requester 1 so out_id/out_data were nonzero beforehand.
      bus.req_bcd1  = 32'h8765_4321;
      bus.req_valid = 2'b10;
      #1;
      check("abort_grant", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_valid = 2'b00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", bus.out_valid, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_data", bus.out_data, 0);
      check("abort_id", bus.out_id, 0);
      check("abort_err", bus.out_err, 0);
      check("abort_ready", bus.req_ready, 2'b00);
      reset = 1'b0;
      last_served = 1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_result", seen, 1'b0);

      // Pointer must be back at 1 after reset: requester 0 wins contention.
      bus.req_bcd0  = rand_word();
      bus.req_bcd1  = rand_word();
      bus.req_valid = 2'b11;
      serve(0, 1'b1);
      serve(0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter NDIGITS, default 8: BCD digits per request.
REQ-002 Parameter BIN_W, default 27: binary result width; SHALL be >= ceil(log2(10^NDIGITS)).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester conversion request (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_bcd0, req_bcd1  input  4*NDIGITS each  packed BCD from requester 0/1; most significant digit in the top nibble.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_data  output  BIN_W  binary value of the accepted BCD word.
REQ-011 out_id  output  1  requester index that owns out_data.
REQ-012 out_err  output  1  invalid-digit flag (see Configuration).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, RUN, DONE; reset state is IDLE.
REQ-015 IDLE: req_ready is asserted for exactly the granted requester when any req_valid bit is high; the handshake (valid & ready) latches the BCD word, clears the accumulator and digit index, records out_id, and moves to RUN.
REQ-016 Arbitration is round-robin: when both request, grant the requester not served last; the last-served pointer resets to 1, so requester 0 wins the first contention.
REQ-017 A single requester is granted regardless of the pointer; the pointer updates only on a completed handshake.
REQ-018 RUN consumes one digit per cycle, most significant first: acc <= acc*10 + digit, truncated modulo 2^BIN_W; the shift-add form (acc<<3)+(acc<<1) is required, with no multiplier.
REQ-019 RUN lasts exactly NDIGITS cycles, then moves to DONE.
REQ-020 Latency: handshake at cycle t -> out_valid first high at cycle t+1+NDIGITS.
REQ-021 DONE holds out_valid, out_data, out_id and out_err stable until out_ready is high; on the cycle out_valid & out_ready is true, the FSM moves to IDLE.
REQ-022 req_ready is 0 in RUN and DONE; requests that stay pending across a conversion are served in IDLE by the REQ-016 rules.
REQ-023 out_valid is 0 in IDLE and RUN; out_data holds its last value outside DONE.
REQ-024 A requester dropping req_valid before its handshake is legal; no grant is recorded.

Reset
REQ-025 Reset forces the FSM to IDLE, sets the pointer to 1, and clears out_valid, out_data, out_id, out_err, busy, req_ready, the accumulator and the digit index.
REQ-026 Reset mid-RUN or mid-DONE aborts the conversion; the result is discarded and never presented.
REQ-027 Reset takes priority over every other event in the same cycle.

Configuration
REQ-028 Macro BCD_CONV_SCHED_DIGIT_CHECK_EN:
- Defined: out_err is set in DONE if any latched nibble exceeds 9; conversion still uses the raw nibble value.
- Undefined: out_err is tied to 0 and the check logic is absent.

Structure
REQ-029 Shared package bcd_pkg holds the FSM state enum (IDLE/RUN/DONE), the digit-width constant (4) and the default NDIGITS/BIN_W constants.
REQ-030 Arbiter is sub-module bcd_rr_arb2 (2-way round-robin; inputs req and handshake-done, outputs one-hot grant); the datapath stays in bcd_conv_sched.

Verification
REQ-031 Req0 with BCD 0x12345678, NDIGITS=8, out_ready=1 -> out_data=12345678 (0xBC614E), out_id=0, out_valid at t+9.
REQ-032 Both requesters valid from reset (req0 0x00000001, req1 0x99999999) -> req0 served first, then req1 yields out_data=99999999, out_id=1; service alternates on repeat.
REQ-033 out_ready held 0 for 5 cycles in DONE -> outputs stable and req_ready=00 throughout; IDLE the cycle after out_ready rises.
REQ-034 Reset asserted at RUN cycle 4 -> out_valid never rises for that request; all outputs 0 next cycle.
REQ-035 With BCD_CONV_SCHED_DIGIT_CHECK_EN, input 0x0000000A -> out_err=1, out_data=10; without the macro -> out_err=0.
REQ-036 Input 0x00000000 -> out_data=0; input 0x99999999 with BIN_W=27 -> out_data=99999999, no truncation.
